// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// | fft_pkg: shared state encoding, default sizes and width helpers           |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  localparam int unsigned FFT_N_DEFAULT     = 16;
  localparam int unsigned FFT_LOG2N_DEFAULT = 4;
  localparam int unsigned FFT_STATE_W       = 3;

  typedef enum logic [FFT_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } fft_state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned fft_cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned fft_stg_w(input int unsigned log2n);
    return fft_cnt_w(log2n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_drain_timer.sv
// ----------------------------------------------------------------------------
// | fft_drain_timer: loadable down-counter with a zero flag                   |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

module fft_drain_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
// ----------------------------------------------------------------------------
// | fft_stage_sequencer: per-stage scheduler of the in-place radix-2 FFT      |
// | Optional watchdog: define FFT_SEQ_TIMEOUT_EN.   Revision: 1.0             |
// ----------------------------------------------------------------------------
`default_nettype none

module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N        = FFT_N_DEFAULT,
  parameter int unsigned LOG2N    = FFT_LOG2N_DEFAULT,
  parameter int unsigned STG_W    = 3,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned TMO_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stage_last,
  output logic             start_stage,
  output logic [STG_W-1:0] stage_idx,
  output logic             bank_sel,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned      DRN_W      = fft_cnt_w(PIPE_LAT - 1);
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(PIPE_LAT - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(LOG2N);

  if ((N != (1 << LOG2N)) || (LOG2N < 2) || (STG_W < fft_stg_w(LOG2N)) ||
      (PIPE_LAT < 1) || (TMO_W < 1)) begin : g_param_check
    $error("fft_stage_sequencer: inconsistent parameter set");
  end

  fft_state_e       state_q, state_d;
  logic [STG_W-1:0] stage_idx_q, stage_idx_d;
  logic             bank_sel_q, bank_sel_d;
  logic             busy_q, busy_d;
  logic             start_acc_q, start_acc_d;
  logic             stage_last_q, stage_last_d;

  logic             last_ev;
  logic             drain_load;
  logic             drain_zero;
  logic             tmo_expire;

  assign last_ev = stage_last & ~stage_last_q;

  fft_drain_timer #(
    .W (DRN_W)
  ) u_drain_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load),
    .load_val (DRAIN_LOAD),
    .en       (state_q == ST_DRAIN),
    .zero     (drain_zero)
  );

  always_comb begin
    state_d      = state_q;
    stage_idx_d  = stage_idx_q;
    bank_sel_d   = bank_sel_q;
    busy_d       = busy_q;
    drain_load   = 1'b0;
    stage_last_d = stage_last;
    // Start is only captured while idle, so a pulse in DONE or mid-run is dropped.
    start_acc_d  = start & (state_q == ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start_acc_q) begin
          state_d     = ST_ISSUE;
          stage_idx_d = STG_W'(1);
          bank_sel_d  = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_RUN;
      ST_RUN: begin
        if (last_ev) begin
          state_d    = ST_DRAIN;
          drain_load = 1'b1;
        end else if (tmo_expire) begin
          state_d     = ST_IDLE;
          stage_idx_d = '0;
          busy_d      = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_zero) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        bank_sel_d = ~bank_sel_q;
        if (stage_idx_q == LAST_STAGE) begin
          state_d     = ST_DONE;
          stage_idx_d = '0;
          busy_d      = 1'b0;
        end else begin
          state_d     = ST_ISSUE;
          stage_idx_d = stage_idx_q + STG_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d     = ST_IDLE;
        stage_idx_d = '0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stage_idx_q  <= '0;
      bank_sel_q   <= 1'b0;
      busy_q       <= 1'b0;
      start_acc_q  <= 1'b0;
      stage_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_idx_q  <= stage_idx_d;
      bank_sel_q   <= bank_sel_d;
      busy_q       <= busy_d;
      start_acc_q  <= start_acc_d;
      stage_last_q <= stage_last_d;
    end
  end

`ifdef FFT_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // Counter restarts every time RUN is entered; reaching all-ones aborts the frame.
  always_comb begin
    tmo_d = (state_q == ST_RUN) ? (tmo_q + TMO_W'(1)) : '0;
    err_d = err_q | ((state_q == ST_RUN) & ~last_ev & tmo_expire);
  end

  assign tmo_expire = (state_q == ST_RUN) && (tmo_d == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_expire = 1'b0;
  assign err        = 1'b0;
`endif

  assign start_stage = (state_q == ST_ISSUE);
  assign done        = (state_q == ST_DONE);
  assign stage_idx   = stage_idx_q;
  assign bank_sel    = bank_sel_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
// ----------------------------------------------------------------------------
// | tb_fft_stage_sequencer: directed scoreboard bench for the stage sequencer |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fft_stage_sequencer;

  localparam int unsigned N        = 16;
  localparam int unsigned LOG2N    = 4;
  localparam int unsigned STG_W    = 3;
  localparam int unsigned PIPE_LAT = 4;
  localparam int unsigned TMO_W    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stage_last = 1'b0;
  logic             start_stage;
  logic [STG_W-1:0] stage_idx;
  logic             bank_sel;
  logic             busy;
  logic             done;
  logic             err;

  fft_stage_sequencer #(
    .N        (N),
    .LOG2N    (LOG2N),
    .STG_W    (STG_W),
    .PIPE_LAT (PIPE_LAT),
    .TMO_W    (TMO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stage_last  (stage_last),
    .start_stage (start_stage),
    .stage_idx   (stage_idx),
    .bank_sel    (bank_sel),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int unsigned idx;
    bit          bank;
    bit          is_done;
  } ev_t;

  ev_t         exp_q[$];
  int          errors   = 0;
  int          checks   = 0;
  int unsigned cyc_n    = 0;
  int unsigned ss_cnt   = 0;
  int unsigned done_cnt = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every start_stage/done pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    ev_t e;
    if (start_stage || done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, start_stage, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_cycle", cyc_n, e.cyc);
        chk("ev_kind", {31'd0, done}, {31'd0, e.is_done});
        chk("ev_idx", {29'd0, stage_idx}, e.idx);
        chk("ev_bank", {31'd0, bank_sel}, {31'd0, e.bank});
        chk("ev_busy", {31'd0, busy}, {31'd0, !e.is_done});
      end
    end
    if (start_stage) ss_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    exp_q.push_back('{cyc: cyc_n + 2, idx: 1, bank: 1'b0, is_done: 1'b0});
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ss(output int unsigned s);
    s = cyc_n;
    for (int i = 0; i < 200; i++) begin
      if (start_stage) begin
        s = cyc_n;
        return;
      end
      tick();
    end
    chk("start_stage_timeout", 32'd1, 32'd0);
  endtask

  // mode 0 plain, 1 held level, 2 spurious start in RUN + stage_last in DRAIN,
  // 3 stage_last pulse during the ISSUE cycle
  task automatic do_stage(input int unsigned k, input int mode);
    int unsigned s;
    int unsigned t;
    wait_ss(s);
    if (mode == 3) begin
      stage_last = 1'b1;
      tick();
      stage_last = 1'b0;
    end
    while (cyc_n < s + 16) begin
      start = (mode == 2) && (cyc_n == s + 5);
      tick();
    end
    start = 1'b0;
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_idx", {29'd0, stage_idx}, k);
    chk("run_bank", {31'd0, bank_sel}, (k - 1) % 2);
    t = cyc_n;
    if (k < LOG2N)
      exp_q.push_back('{cyc: t + PIPE_LAT + 2, idx: k + 1, bank: k[0], is_done: 1'b0});
    else
      exp_q.push_back('{cyc: t + PIPE_LAT + 2, idx: 0, bank: 1'b0, is_done: 1'b1});
    stage_last = 1'b1;
    if (mode == 1) begin
      repeat (5) tick();
    end else begin
      tick();
    end
    stage_last = 1'b0;
    if (mode == 2) begin
      tick();
      stage_last = 1'b1;
      tick();
      stage_last = 1'b0;
    end
  endtask

  task automatic run_frame(input int m1, input int m2, input int m3, input int m4,
                           input bit start_in_done);
    int unsigned ss0;
    int unsigned d0;
    ss0 = ss_cnt;
    d0  = done_cnt;
    pulse_start();
    do_stage(1, m1);
    do_stage(2, m2);
    do_stage(3, m3);
    do_stage(4, m4);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
    chk("pending_events", exp_q.size(), 32'd0);
    chk("done_level", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    start = start_in_done;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("ss_count", ss_cnt - ss0, LOG2N);
    chk("done_count", done_cnt - d0, 32'd1);
    chk("idle_bank", {31'd0, bank_sel}, 32'd0);
    chk("idle_idx", {29'd0, stage_idx}, 32'd0);
    chk("idle_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned s;
    int unsigned d0;

    // Reset held for three cycles: every output low.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {25'd0, start_stage, stage_idx, bank_sel, busy, done, err}, 32'd0);
    end
    rst = 1'b0;
    tick();

    // Plain full run, plus a start pulse in the DONE cycle that must be dropped.
    run_frame(0, 0, 0, 0, 1'b1);

    // Held level, spurious start/stage_last, event during ISSUE.
    run_frame(1, 2, 3, 0, 1'b0);

    // Reset while stage 3 is draining.
    d0 = done_cnt;
    pulse_start();
    do_stage(1, 0);
    do_stage(2, 0);
    wait_ss(s);
    while (cyc_n < s + 16) tick();
    stage_last = 1'b1;
    tick();
    stage_last = 1'b0;
    tick();
    chk("drain_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_idx", {29'd0, stage_idx}, 32'd0);
    chk("midrst_bank", {31'd0, bank_sel}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (10) tick();
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    run_frame(0, 0, 0, 0, 1'b0);

`ifdef FFT_SEQ_TIMEOUT_EN
    // Watchdog: stage_last never comes.
    d0 = done_cnt;
    pulse_start();
    wait_ss(s);
    while (cyc_n < s + 15) tick();
    chk("tmo_err_early", {31'd0, err}, 32'd0);
    tick();
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    chk("tmo_err_sticky", {31'd0, err}, 32'd1);
    chk("tmo_no_done", done_cnt - d0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("tmo_err_cleared", {31'd0, err}, 32'd0);
`endif

    chk("final_queue", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
